// File: rtl/flash_arb_pkg.sv
// Shared types and sizing helpers for the program-flash port arbiter.
package flash_arb_pkg;

    // Records which requester owns the read that is in flight to the flash.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LPM   = 2'd2
    } owner_t;

    localparam int FLASH_WIDTH_DEF  = 14;
    localparam int STARVE_LIMIT_DEF = 4;

    // The starve counter must be able to hold STARVE_LIMIT. A limit of 0 still needs a
    // 1-bit counter so that the vector stays legal.
    function automatic int starve_cnt_w(input int limit);
        int w;
        if (limit < 1) begin
            w = 1;
        end else begin
            w = $clog2(limit + 1);
        end
        return w;
    endfunction

    localparam int STARVE_W_DEF = starve_cnt_w(STARVE_LIMIT_DEF);

endpackage

// File: rtl/flash_arb_starve_ctr.sv
// Saturating count of consecutive cycles in which fetch asked and was refused.
// When the count reaches STARVE_LIMIT, force_fetch tells the arbiter to let fetch
// through on the next contended cycle. STARVE_LIMIT = 0 disables the guard.
module flash_arb_starve_ctr
    import flash_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ifetch_req,
    input  logic ifetch_gnt,
    output logic force_fetch
);

    localparam int CW = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt;

    // Count refusals. A grant or a withdrawn request restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!ifetch_req || ifetch_gnt) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A limit of 0 gives strict LPM priority, so the guard never fires.
    assign force_fetch = (STARVE_LIMIT > 0) && (cnt == LIMIT);

endmodule

// File: rtl/flash_port_arbiter.sv
// Lets instruction fetch and the LPM byte-load path share the single-port program
// flash. Each cycle at most one requester is granted. The owner of each read is
// tagged so that the word or byte coming back is steered to that owner one cycle
// later. LPM normally has priority, and a starvation guard bounds how long fetch
// can be held off.
module flash_port_arbiter
    import flash_arb_pkg::*;
#(
    parameter int FLASH_WIDTH  = FLASH_WIDTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   ifetch_req,
    input  logic [FLASH_WIDTH-1:0] ifetch_addr,
    output logic                   ifetch_gnt,
    output logic                   ifetch_valid,
    output logic [15:0]            ifetch_data,

    input  logic                   lpm_req,
    input  logic [FLASH_WIDTH:0]   lpm_addr,
    output logic                   lpm_gnt,
    output logic                   lpm_valid,
    output logic [7:0]             lpm_data,

    output logic                   flash_ce,
    output logic [FLASH_WIDTH-1:0] flash_a,
    input  logic [15:0]            flash_d
);

    logic        force_fetch;
    owner_t      owner_q;
    logic        sel_q;
    logic [15:0] ifetch_hold;
    logic [7:0]  lpm_hold;
    logic [7:0]  lpm_byte;

    flash_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifetch_req  (ifetch_req),
        .ifetch_gnt  (ifetch_gnt),
        .force_fetch (force_fetch)
    );

    // Arbitration and address mux. LPM wins a contended cycle unless fetch has been
    // starved. When idle, the fetch address is kept on flash_a so the bus stays quiet.
    always_comb begin
        lpm_gnt    = lpm_req && !(ifetch_req && force_fetch);
        ifetch_gnt = ifetch_req && !lpm_gnt;
        flash_ce   = ifetch_gnt || lpm_gnt;
        flash_a    = lpm_gnt ? lpm_addr[FLASH_WIDTH:1] : ifetch_addr;
    end

    // Tag the read issued this cycle. The byte select is kept alongside the LPM tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
            sel_q   <= 1'b0;
        end else begin
            if (ifetch_gnt) begin
                owner_q <= OWN_FETCH;
            end else if (lpm_gnt) begin
                owner_q <= OWN_LPM;
            end else begin
                owner_q <= OWN_NONE;
            end
            if (lpm_gnt) begin
                sel_q <= lpm_addr[0];
            end
        end
    end

    assign lpm_byte = sel_q ? flash_d[15:8] : flash_d[7:0];

    // Capture returned data for its owner so each port holds its last value. The
    // registers update only on their own port's response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifetch_hold <= 16'h0000;
            lpm_hold    <= 8'h00;
        end else begin
            if (owner_q == OWN_FETCH) begin
                ifetch_hold <= flash_d;
            end
            if (owner_q == OWN_LPM) begin
                lpm_hold <= lpm_byte;
            end
        end
    end

    // The flash already registers its read, so the tagged cycle can present flash_d
    // directly. This keeps the grant-to-valid latency at one cycle. Without a tag,
    // flash_d cannot reach either port.
    assign ifetch_valid = (owner_q == OWN_FETCH);
    assign lpm_valid    = (owner_q == OWN_LPM);
    assign ifetch_data  = ifetch_valid ? flash_d : ifetch_hold;
    assign lpm_data     = lpm_valid ? lpm_byte : lpm_hold;

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Bench for flash_port_arbiter. It runs two instances from shared stimulus: A uses the
// default starve limit of 4, and B uses limit 0 (strict LPM priority). Each instance
// has its own registered flash model. Grants seen on A push expected responses into a
// scoreboard, and those responses are popped and compared one cycle later.
module tb_flash_port_arbiter;

    localparam int FW = 14;

    typedef struct {
        bit          is_lpm;
        logic [15:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ifetch_req;
    logic [FW-1:0] ifetch_addr;
    logic          lpm_req;
    logic [FW:0]   lpm_addr;

    logic          a_ifetch_gnt, a_ifetch_valid, a_lpm_gnt, a_lpm_valid, a_flash_ce;
    logic [15:0]   a_ifetch_data, a_flash_d;
    logic [7:0]    a_lpm_data;
    logic [FW-1:0] a_flash_a;

    logic          b_ifetch_gnt, b_ifetch_valid, b_lpm_gnt, b_lpm_valid, b_flash_ce;
    logic [15:0]   b_ifetch_data, b_flash_d;
    logic [7:0]    b_lpm_data;
    logic [FW-1:0] b_flash_a;

    logic [15:0] mem [0:(1<<FW)-1];

    int    total = 0;
    int    bad   = 0;
    exp_t  sb[$];
    int    alog[$];
    int    blog[$];
    logic [15:0] exp_idata = 16'h0000;
    logic [7:0]  exp_ldata = 8'h00;

    always #5 clk = ~clk;

    flash_port_arbiter #(.FLASH_WIDTH(FW), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_gnt(a_ifetch_gnt),
        .ifetch_valid(a_ifetch_valid), .ifetch_data(a_ifetch_data),
        .lpm_req(lpm_req), .lpm_addr(lpm_addr), .lpm_gnt(a_lpm_gnt),
        .lpm_valid(a_lpm_valid), .lpm_data(a_lpm_data),
        .flash_ce(a_flash_ce), .flash_a(a_flash_a), .flash_d(a_flash_d)
    );

    flash_port_arbiter #(.FLASH_WIDTH(FW), .STARVE_LIMIT(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_gnt(b_ifetch_gnt),
        .ifetch_valid(b_ifetch_valid), .ifetch_data(b_ifetch_data),
        .lpm_req(lpm_req), .lpm_addr(lpm_addr), .lpm_gnt(b_lpm_gnt),
        .lpm_valid(b_lpm_valid), .lpm_data(b_lpm_data),
        .flash_ce(b_flash_ce), .flash_a(b_flash_a), .flash_d(b_flash_d)
    );

    // Registered-read flash models; their contents are deliberately not reset.
    always @(posedge clk) begin
        if (a_flash_ce) a_flash_d <= mem[a_flash_a];
        if (b_flash_ce) b_flash_d <= mem[b_flash_a];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for instance A, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            exp_idata = 16'h0000;
            exp_ldata = 8'h00;
            chk("rst_ivalid", 32'(a_ifetch_valid), 32'd0);
            chk("rst_lvalid", 32'(a_lpm_valid), 32'd0);
            chk("rst_idata", 32'(a_ifetch_data), 32'h0000);
            chk("rst_ldata", 32'(a_lpm_data), 32'h00);
        end else begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ivalid", 32'(a_ifetch_valid), 32'(!e.is_lpm));
                chk("lvalid", 32'(a_lpm_valid), 32'(e.is_lpm));
                if (e.is_lpm) exp_ldata = e.data[7:0];
                else          exp_idata = e.data;
            end else begin
                chk("idle_ivalid", 32'(a_ifetch_valid), 32'd0);
                chk("idle_lvalid", 32'(a_lpm_valid), 32'd0);
            end
            chk("idata", 32'(a_ifetch_data), 32'(exp_idata));
            chk("ldata", 32'(a_lpm_data), 32'(exp_ldata));

            chk("ce", 32'(a_flash_ce), 32'(ifetch_req | lpm_req));
            chk("gnt_count", 32'(a_ifetch_gnt) + 32'(a_lpm_gnt), 32'(ifetch_req | lpm_req));
            if (ifetch_req && !lpm_req) chk("solo_fetch", 32'(a_ifetch_gnt), 32'd1);
            if (lpm_req && !ifetch_req) chk("solo_lpm", 32'(a_lpm_gnt), 32'd1);
            if (!ifetch_req && !lpm_req) chk("idle_a", 32'(a_flash_a), 32'(ifetch_addr));

            if (a_ifetch_gnt) begin
                chk("fa_fetch", 32'(a_flash_a), 32'(ifetch_addr));
                sb.push_back('{1'b0, mem[ifetch_addr]});
            end else if (a_lpm_gnt) begin
                chk("fa_lpm", 32'(a_flash_a), 32'(lpm_addr[FW:1]));
                if (lpm_addr[0]) sb.push_back('{1'b1, {8'h00, mem[lpm_addr[FW:1]][15:8]}});
                else             sb.push_back('{1'b1, {8'h00, mem[lpm_addr[FW:1]][7:0]}});
            end
            alog.push_back(a_ifetch_gnt ? 1 : (a_lpm_gnt ? 2 : 0));
            blog.push_back(b_ifetch_gnt ? 1 : (b_lpm_gnt ? 2 : 0));
        end
    end

    initial begin
        int nf, nl;
        for (int i = 0; i < (1 << FW); i++) mem[i] = 16'(i) ^ 16'h5A5A;
        mem[14'h0010] = 16'hBEEF;
        mem[14'h0020] = 16'h1234;
        mem[14'h0030] = 16'hCAFE;

        rst_n = 1'b0; ifetch_req = 1'b0; lpm_req = 1'b0;
        ifetch_addr = '0; lpm_addr = '0;
        repeat (3) tick();
        chk("reset_gnt_follow", 32'(a_flash_ce), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: fetch only
        ifetch_addr = 14'h0010; ifetch_req = 1'b1;
        #1 chk("t1_gnt", 32'(a_ifetch_gnt), 32'd1);
        tick();
        ifetch_req = 1'b0;
        chk("t1_valid", 32'(a_ifetch_valid), 32'd1);
        chk("t1_data", 32'(a_ifetch_data), 32'hBEEF);
        chk("t1_lvalid", 32'(a_lpm_valid), 32'd0);
        tick();

        // 2: LPM high byte then low byte of the same word
        lpm_addr = 15'h0021; lpm_req = 1'b1;
        tick();
        chk("t2_hi", 32'(a_lpm_data), 32'hBE);
        lpm_addr = 15'h0020;
        tick();
        lpm_req = 1'b0;
        chk("t2_lo", 32'(a_lpm_data), 32'hEF);
        tick();

        // 3: contention with the starve guard at 4
        ifetch_addr = 14'h0030; lpm_addr = 15'h0041;
        ifetch_req = 1'b1; lpm_req = 1'b1;
        alog.delete();
        repeat (10) tick();
        ifetch_req = 1'b0; lpm_req = 1'b0;
        chk("t3_len", 32'(alog.size()), 32'd10);
        for (int i = 0; i < 10 && i < alog.size(); i++)
            chk($sformatf("t3_gnt%0d", i), 32'(alog[i]), (i % 5 == 4) ? 32'd1 : 32'd2);
        chk("t3_idata", 32'(a_ifetch_data), 32'hCAFE);
        chk("t3_ldata", 32'(a_lpm_data), 32'h12);
        tick();

        // 4: strict LPM priority on instance B
        ifetch_req = 1'b1; lpm_req = 1'b1;
        blog.delete();
        repeat (8) tick();
        ifetch_req = 1'b0; lpm_req = 1'b0;
        nf = 0; nl = 0;
        foreach (blog[i]) begin
            if (blog[i] == 1) nf++;
            if (blog[i] == 2) nl++;
        end
        chk("t4_lpm", 32'(nl), 32'd8);
        chk("t4_fetch", 32'(nf), 32'd0);
        tick();

        // 5: reset lands while a fetch response is due
        ifetch_addr = 14'h0020; ifetch_req = 1'b1;
        tick();
        ifetch_req = 1'b0; rst_n = 1'b0;
        #1;
        chk("t5_ivalid", 32'(a_ifetch_valid), 32'd0);
        chk("t5_idata", 32'(a_ifetch_data), 32'h0000);
        chk("t5_ldata", 32'(a_lpm_data), 32'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_noval", 32'(a_ifetch_valid), 32'd0);
        ifetch_addr = 14'h0010; ifetch_req = 1'b1;
        tick();
        ifetch_req = 1'b0;
        chk("t5_valid", 32'(a_ifetch_valid), 32'd1);
        chk("t5_data", 32'(a_ifetch_data), 32'hBEEF);
        tick();

        // 6: idle hold
        repeat (5) begin
            tick();
            chk("t6_ce", 32'(a_flash_ce), 32'd0);
            chk("t6_ivalid", 32'(a_ifetch_valid), 32'd0);
            chk("t6_idata", 32'(a_ifetch_data), 32'hBEEF);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
